// File: rtl/cpu_pkg.sv
// Shared types and codes for the instruction sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam logic [1:0] FMT_RALU = 2'b00;
  localparam logic [1:0] FMT_IALU = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;
  localparam logic [1:0] FMT_CTRL = 2'b11;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  // True when a control instruction redirects the PC by its immediate.
  function automatic logic ctrlTaken(input logic [3:0] op, input logic flag);
    return ((op == OP_BR) && flag) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Host-side handshake and decoded-instruction bus of the sequencer.
interface cpu_sequencer_if #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start_i;
  logic [PC_WIDTH-1:0]  start_address_i;
  logic [1:0]           format_i;
  logic [3:0]           opcode_i;
  logic [2:0]           imm_i;
  logic                 alu_branch_i;
  logic [PC_WIDTH-1:0]  pc_o;
  logic                 ir_load_o;
  logic                 reg_write_o;
  logic                 mem_read_o;
  logic                 mem_write_o;
  logic                 wb_sel_o;
  logic                 busy_o;
  logic                 halted_o;
  logic [CNT_WIDTH-1:0] retired_o;

  modport master (
    output start_i, start_address_i, format_i, opcode_i, imm_i, alu_branch_i,
    input  pc_o, ir_load_o, reg_write_o, mem_read_o, mem_write_o, wb_sel_o,
           busy_o, halted_o, retired_o
  );

  modport slave (
    input  start_i, start_address_i, format_i, opcode_i, imm_i, alu_branch_i,
    output pc_o, ir_load_o, reg_write_o, mem_read_o, mem_write_o, wb_sel_o,
           busy_o, halted_o, retired_o
  );
endinterface

// File: rtl/pc_unit.sv
// Next-PC computation: hold, load start address, or advance with optional offset.
module pc_unit #(
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] startAddress,
  input  logic [2:0]          imm,
  input  logic                loadStart,
  input  logic                advance,
  input  logic                useOffset,
  output logic [PC_WIDTH-1:0] nextPc
);

  logic [PC_WIDTH-1:0] offset;

  // Sign-extend the immediate and select the next PC; arithmetic wraps naturally.
  always_comb begin
    offset = '0;
    nextPc = pc;
    if (useOffset) offset = {{(PC_WIDTH-3){imm[2]}}, imm};
    if (loadStart) nextPc = startAddress;
    else if (advance) nextPc = pc + offset + PC_WIDTH'(1);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback control.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_i,
  cpu_sequencer_if.slave bus
);

  state_t stateQ, stateD;

  logic [1:0]           fmtQ;
  logic [3:0]           opQ;
  logic [2:0]           immQ;
  logic [PC_WIDTH-1:0]  pcQ, nextPc;
  logic [CNT_WIDTH-1:0] retiredQ;

  logic loadStart, advance, useOffset, retireInc, retireClr, capture;
  logic irLoadD, regWriteD, memReadD, memWriteD, wbSelD, busyD, haltedD;
  logic irLoadQ, regWriteQ, memReadQ, memWriteQ, wbSelQ, busyQ, haltedQ;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // Next-state, datapath controls and next Moore outputs.
  always_comb begin
    stateD    = stateQ;
    loadStart = 1'b0;
    advance   = 1'b0;
    useOffset = 1'b0;
    retireInc = 1'b0;
    retireClr = 1'b0;
    capture   = 1'b0;
    case (stateQ)
      IDLE, HALT: begin
        if (bus.start_i) begin
          stateD    = FETCH;
          loadStart = 1'b1;
          retireClr = 1'b1;
        end
      end
      FETCH: stateD = DECODE;
      DECODE: begin
        capture = 1'b1;
        if ((bus.format_i == FMT_CTRL) && (bus.opcode_i == OP_HALT)) begin
          stateD    = HALT;
          retireInc = 1'b1;
        end else begin
          stateD = EXECUTE;
        end
      end
      EXECUTE: begin
        case (fmtQ)
          FMT_MEM:  stateD = MEM;
          FMT_CTRL: begin
            stateD    = FETCH;
            advance   = 1'b1;
            useOffset = ctrlTaken(opQ, bus.alu_branch_i);
            retireInc = 1'b1;
          end
          default:  stateD = WB;
        endcase
      end
      MEM: begin
        if (opQ[0]) begin
          stateD    = FETCH;
          advance   = 1'b1;
          retireInc = 1'b1;
        end else begin
          stateD = WB;
        end
      end
      WB: begin
        stateD    = FETCH;
        advance   = 1'b1;
        retireInc = 1'b1;
      end
      default: stateD = IDLE;
    endcase

    // Outputs for the state being entered; MEM/WB only follow EXECUTE, so fields are latched.
    irLoadD   = (stateD == DECODE);
    regWriteD = (stateD == WB);
    memReadD  = (stateD == MEM) && !opQ[0];
    memWriteD = (stateD == MEM) && opQ[0];
    wbSelD    = (stateD == WB) && (fmtQ == FMT_MEM) && !opQ[0];
    busyD     = (stateD != IDLE) && (stateD != HALT);
    haltedD   = (stateD == HALT);
  end

  pc_unit #(.PC_WIDTH(PC_WIDTH)) uPcUnit (
    .pc           (pcQ),
    .startAddress (bus.start_address_i),
    .imm          (immQ),
    .loadStart    (loadStart),
    .advance      (advance),
    .useOffset    (useOffset),
    .nextPc       (nextPc)
  );

  // PC, retired counter, latched instruction fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      pcQ       <= '0;
      retiredQ  <= '0;
      fmtQ      <= '0;
      opQ       <= '0;
      immQ      <= '0;
      irLoadQ   <= 1'b0;
      regWriteQ <= 1'b0;
      memReadQ  <= 1'b0;
      memWriteQ <= 1'b0;
      wbSelQ    <= 1'b0;
      busyQ     <= 1'b0;
      haltedQ   <= 1'b0;
    end else begin
      pcQ <= nextPc;
      if (retireClr)      retiredQ <= '0;
      else if (retireInc) retiredQ <= retiredQ + CNT_WIDTH'(1);
      if (capture) begin
        fmtQ <= bus.format_i;
        opQ  <= bus.opcode_i;
        immQ <= bus.imm_i;
      end
      irLoadQ   <= irLoadD;
      regWriteQ <= regWriteD;
      memReadQ  <= memReadD;
      memWriteQ <= memWriteD;
      wbSelQ    <= wbSelD;
      busyQ     <= busyD;
      haltedQ   <= haltedD;
    end
  end

  // Side-effect strobes are suppressed in the reset cycle itself so an aborted access never fires.
  assign bus.pc_o        = pcQ;
  assign bus.retired_o   = retiredQ;
  assign bus.ir_load_o   = irLoadQ;
  assign bus.reg_write_o = regWriteQ & ~rst_i;
  assign bus.mem_read_o  = memReadQ & ~rst_i;
  assign bus.mem_write_o = memWriteQ & ~rst_i;
  assign bus.wb_sel_o    = wbSelQ;
  assign bus.busy_o      = busyQ;
  assign bus.halted_o    = haltedQ;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for the instruction sequencer.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_i;
  int   tests = 0;
  int   fails = 0;

  cpu_sequencer_if #(.PC_WIDTH(16), .CNT_WIDTH(16)) bus ();

  cpu_sequencer #(.PC_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction while in FETCH and step through the given number of cycles.
  task automatic runInstr(input logic [1:0] fmt, input logic [3:0] op, input logic [2:0] imm,
                          input logic br, input int cycles);
    bus.format_i     = fmt;
    bus.opcode_i     = op;
    bus.imm_i        = imm;
    bus.alu_branch_i = br;
    repeat (cycles) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i               = 1'b1;
    bus.start_i         = 1'b0;
    bus.start_address_i = '0;
    bus.format_i        = '0;
    bus.opcode_i        = '0;
    bus.imm_i           = '0;
    bus.alu_branch_i    = 1'b0;
    tick();
    tick();
    check("rst_pc", bus.pc_o, 0);
    check("rst_retired", bus.retired_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_halted", bus.halted_o, 0);
    check("rst_strobes", {bus.ir_load_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.wb_sel_o}, 0);
    rst_i = 1'b0;
    tick();
    check("idle_busy", bus.busy_o, 0);

    // R-ALU from address 5.
    bus.start_address_i = 16'd5;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("alu_fetch_pc", bus.pc_o, 5);
    check("alu_fetch_busy", bus.busy_o, 1);
    runInstr(2'b00, 4'h3, 3'b000, 1'b0, 1);
    check("alu_irload", bus.ir_load_o, 1);
    tick();
    check("alu_exec_nowrite", bus.reg_write_o, 0);
    tick();
    check("alu_wb_write", {bus.reg_write_o, bus.wb_sel_o}, 2'b10);
    tick();
    check("alu_pc", bus.pc_o, 6);
    check("alu_retired", bus.retired_o, 1);
    check("alu_strobe_single", bus.reg_write_o, 0);

    // I-ALU at 6, then load at 7.
    runInstr(2'b01, 4'h2, 3'b000, 1'b0, 4);
    check("ialu_pc", bus.pc_o, 7);
    runInstr(2'b10, 4'h0, 3'b000, 1'b0, 2);
    check("load_exec", {bus.mem_read_o, bus.reg_write_o}, 2'b00);
    tick();
    check("load_mem", {bus.mem_read_o, bus.mem_write_o, bus.reg_write_o}, 3'b100);
    tick();
    check("load_wb", {bus.reg_write_o, bus.wb_sel_o, bus.mem_read_o}, 3'b110);
    tick();
    check("load_pc", bus.pc_o, 8);
    check("load_retired", bus.retired_o, 3);

    // Store at 8.
    runInstr(2'b10, 4'h1, 3'b000, 1'b0, 3);
    check("store_mem", {bus.mem_write_o, bus.mem_read_o, bus.reg_write_o}, 3'b100);
    tick();
    check("store_pc", bus.pc_o, 9);
    check("store_nowrite", {bus.reg_write_o, bus.mem_write_o}, 2'b00);
    check("store_retired", bus.retired_o, 4);

    // Branch not taken 9 -> 10, then taken -2 at 10 -> 9.
    runInstr(2'b11, 4'h0, 3'b110, 1'b0, 3);
    check("br_nt_pc9", bus.pc_o, 10);
    runInstr(2'b11, 4'h0, 3'b110, 1'b1, 3);
    check("br_taken_pc", bus.pc_o, 9);
    check("br_retired", bus.retired_o, 6);

    // ALU to 10, then not-taken branch with a start pulse that must be ignored.
    runInstr(2'b00, 4'h0, 3'b000, 1'b0, 4);
    bus.start_address_i = 16'd100;
    bus.start_i = 1'b1;
    runInstr(2'b11, 4'h0, 3'b110, 1'b0, 3);
    bus.start_i = 1'b0;
    check("br_nt_pc11", bus.pc_o, 11);
    check("start_ignored_busy", bus.busy_o, 1);

    // Unknown control opcode behaves as a 3-cycle no-op.
    runInstr(2'b11, 4'h5, 3'b011, 1'b1, 3);
    check("nop_pc", bus.pc_o, 12);
    check("nop_retired", bus.retired_o, 9);

    // HALT: two cycles from FETCH.
    runInstr(2'b11, 4'hF, 3'b000, 1'b0, 1);
    check("halt_not_yet", bus.halted_o, 0);
    tick();
    check("halt_set", {bus.halted_o, bus.busy_o}, 2'b10);
    check("halt_retired", bus.retired_o, 10);
    tick();
    tick();
    check("halt_stays", bus.halted_o, 1);

    // Restart at FFFF; ALU wraps PC to 0.
    bus.start_address_i = 16'hFFFF;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("wrap_fetch_pc", bus.pc_o, 16'hFFFF);
    check("wrap_retired_clr", bus.retired_o, 0);
    check("wrap_halted_clr", bus.halted_o, 0);
    runInstr(2'b00, 4'h1, 3'b000, 1'b0, 4);
    check("wrap_pc", bus.pc_o, 0);

    // Halt, restart at FFFE; jump +3 wraps to 2.
    runInstr(2'b11, 4'hF, 3'b000, 1'b0, 2);
    bus.start_address_i = 16'hFFFE;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    runInstr(2'b11, 4'h1, 3'b011, 1'b0, 3);
    check("jmp_wrap_pc", bus.pc_o, 2);
    check("jmp_retired", bus.retired_o, 1);

    // Halt, restart at 0 after halt.
    runInstr(2'b11, 4'hF, 3'b000, 1'b0, 2);
    check("halt2_set", bus.halted_o, 1);
    bus.start_address_i = 16'h0000;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("restart_pc", bus.pc_o, 0);
    check("restart_state", {bus.busy_o, bus.halted_o, bus.retired_o}, 18'b10_0000_0000_0000_0000);

    // ALU to 1, then reset during MEM of a store.
    runInstr(2'b00, 4'h0, 3'b000, 1'b0, 4);
    check("pre_rst_pc", bus.pc_o, 1);
    runInstr(2'b10, 4'h1, 3'b000, 1'b0, 3);
    rst_i = 1'b1;
    bus.start_i = 1'b1;
    #1;
    check("rst_mem_nowrite", bus.mem_write_o, 0);
    tick();
    check("rst_mid_busy", bus.busy_o, 0);
    check("rst_mid_pc", bus.pc_o, 0);
    check("rst_mid_retired", bus.retired_o, 1'b0);
    check("rst_mid_strobes", {bus.ir_load_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.wb_sel_o, bus.halted_o}, 0);
    rst_i = 1'b0;
    bus.start_i = 1'b0;
    tick();
    check("post_rst_idle", {bus.busy_o, bus.mem_write_o}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 16, sets the program counter and start-address width.
REQ-002 Parameter CNT_WIDTH, default 16, sets the retired-instruction counter width.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  begin execution at start_address_i; honoured only in IDLE or HALT.
REQ-006 start_address_i  in  PC_WIDTH  initial PC.
REQ-007 format_i  in  2  decoded format: 00 R-ALU, 01 I-ALU, 10 memory, 11 control.
REQ-008 opcode_i  in  4  decoded opcode.
REQ-009 imm_i  in  3  immediate field, two's complement for branches.
REQ-010 alu_branch_i  in  1  ALU condition flag, valid in EXECUTE.
REQ-011 pc_o  out  PC_WIDTH  current PC, drives instruction ROM.
REQ-012 ir_load_o  out  1  latch decoded fields (DECODE).
REQ-013 reg_write_o  out  1  register-file write strobe.
REQ-014 mem_read_o / mem_write_o  out  1 each  data-memory strobes.
REQ-015 wb_sel_o  out  1  writeback source: 0 ALU, 1 memory.
REQ-016 busy_o  out  1  high in any state other than IDLE and HALT.
REQ-017 halted_o  out  1  high in HALT.
REQ-018 retired_o  out  CNT_WIDTH  count of completed instructions.

Function
REQ-019 States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT; one cycle each; state register is registered, strobes are Moore outputs of state plus latched format/opcode.
REQ-020 IDLE/HALT with start_i=1 -> FETCH next cycle, pc_o <= start_address_i, retired_o <= 0.
REQ-021 FETCH -> DECODE; DECODE asserts ir_load_o and captures format_i, opcode_i, imm_i; control format with opcode 4'hF -> HALT, else -> EXECUTE.
REQ-022 EXECUTE: format 00/01 -> WB; format 10 -> MEM; format 11 -> FETCH.
REQ-023 MEM: mem_read_o=1 if opcode[0]=0 (load) -> WB; mem_write_o=1 if opcode[0]=1 (store) -> FETCH.
REQ-024 WB: reg_write_o=1; wb_sel_o=1 for load, else 0 -> FETCH.
REQ-025 Latency: ALU 4 cycles, load 5, store 4, branch/jump 3, FETCH to HALT 2.
REQ-026 PC update on final cycle of each instruction: pc+1, except control opcode 0000 with alu_branch_i=1 and opcode 0001 (jump): pc + sign-extended imm_i + 1.
REQ-027 PC arithmetic modulo 2^PC_WIDTH; 16'hFFFF+1 wraps to 0; negative offsets wrap likewise.
REQ-028 Unknown control opcodes execute as no-op (pc+1, 3 cycles).
REQ-029 retired_o increments by 1 on each instruction's final cycle and on entry to HALT; wraps at 2^CNT_WIDTH.
REQ-030 start_i is ignored while busy_o=1.
REQ-031 All strobes are single-cycle; at most one of reg_write_o, mem_read_o, mem_write_o is high in any cycle.

Reset
REQ-032 rst_i=1 forces IDLE on the next edge, overriding start_i and any state, including mid-instruction.
REQ-033 Reset values: pc_o=0, retired_o=0, all strobes 0, wb_sel_o=0, busy_o=0, halted_o=0, latched fields 0.
REQ-034 An in-flight store or writeback aborted by reset produces no strobe in the reset cycle or afterwards.

Structure
REQ-035 Shared package cpu_pkg holds the state enum, format codes (FMT_RALU, FMT_IALU, FMT_MEM, FMT_CTRL), and control opcodes (OP_BR=4'h0, OP_JMP=4'h1, OP_HALT=4'hF).
REQ-036 One sub-module, pc_unit, computes next PC (increment, sign-extended offset, load start address).

Verification
REQ-037 start_address_i=5, R-ALU instruction, start pulse -> pc_o=5 in FETCH, reg_write_o high in 4th cycle, pc_o=6, retired_o=1.
REQ-038 Load at pc 7 -> mem_read_o in cycle 4, reg_write_o with wb_sel_o=1 in cycle 5; store -> mem_write_o in cycle 4, no reg_write_o.
REQ-039 Branch imm=3'b110 (-2) at pc 10 with alu_branch_i=1 -> pc_o=9; alu_branch_i=0 -> pc_o=11.
REQ-040 pc 16'hFFFF non-branch -> pc_o=0; jump imm=3 at 16'hFFFE -> pc_o=2.
REQ-041 HALT opcode -> halted_o=1 after 2 cycles, stays until start_i=1 with start_address_i=0 -> FETCH at pc 0, retired_o=0.
REQ-042 rst_i asserted during MEM of a store -> no mem_write_o, IDLE next cycle, all outputs at reset values; start_i during busy ignored.
